// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of a single SDRAM controller: port 0 (video) has
// priority with starvation protection, ports 1/2 share round-robin.
module sdram_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sdram_init_done,
    input  logic                  ctrl_idle,
    input  logic [2:0]            req,
    input  logic [2:0]            req_wr,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [26:0]           req_len,
    output logic [2:0]            grant,
    output logic [2:0]            done,
    output logic [2:0]            wr_ack_o,
    output logic [2:0]            rd_ack_o,
    output logic                  sdram_wr_req,
    output logic                  sdram_rd_req,
    output logic [8:0]            sdwr_byte,
    output logic [8:0]            sdrd_byte,
    output logic [ADDR_W-1:0]     sys_addr,
    input  logic                  sdram_wr_ack,
    input  logic                  sdram_rd_ack
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, WAIT_IDLE} state_t;

    state_t              state;
    logic                wr_dir;
    logic [8:0]          len_q;
    logic [8:0]          ack_cnt;
    logic [SW-1:0]       starve_cnt;
    logic                rr_ptr;      // 0: port 1 preferred, 1: port 2 preferred

    logic                lo_req;
    logic                starve_hit;
    logic [2:0]          pick;
    logic [1:0]          sel;
    logic [ADDR_W-1:0]   sel_addr;
    logic [8:0]          raw_len;
    logic [8:0]          sel_len;
    logic                sel_wr;
    logic                ack_match;
    logic [8:0]          cnt_next;

    always_comb begin
        lo_req     = req[1] | req[2];
        starve_hit = (starve_cnt == SW'(STARVE_MAX));
        pick       = '0;
        if (req[0] && !(starve_hit && lo_req)) begin
            pick = 3'b001;
        end else if (!rr_ptr) begin
            if (req[1])      pick = 3'b010;
            else if (req[2]) pick = 3'b100;
        end else begin
            if (req[2])      pick = 3'b100;
            else if (req[1]) pick = 3'b010;
        end
        sel      = pick[2] ? 2'd2 : (pick[1] ? 2'd1 : 2'd0);
        sel_addr = req_addr[32'(sel) * ADDR_W +: ADDR_W];
        raw_len  = req_len[32'(sel) * 9 +: 9];
        sel_wr   = req_wr[sel];
        if (raw_len == 9'd0)        sel_len = 9'd1;
        else if (raw_len > 9'd256)  sel_len = 9'd256;
        else                        sel_len = raw_len;
        ack_match = wr_dir ? sdram_wr_ack : sdram_rd_ack;
        cnt_next  = ack_cnt + {8'd0, ack_match};
    end

    assign wr_ack_o = grant & {3{sdram_wr_ack}};
    assign rd_ack_o = grant & {3{sdram_rd_ack}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            done         <= '0;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            sdwr_byte    <= '0;
            sdrd_byte    <= '0;
            sys_addr     <= '0;
            wr_dir       <= 1'b0;
            len_q        <= '0;
            ack_cnt      <= '0;
            starve_cnt   <= '0;
            rr_ptr       <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (sdram_init_done && ctrl_idle && |req) begin
                        grant        <= pick;
                        sys_addr     <= sel_addr;
                        sdwr_byte    <= sel_len;
                        sdrd_byte    <= sel_len;
                        len_q        <= sel_len;
                        wr_dir       <= sel_wr;
                        sdram_wr_req <= sel_wr;
                        sdram_rd_req <= !sel_wr;
                        ack_cnt      <= '0;
                        // A port-0 grant with nobody else waiting ends the starvation streak
                        if (pick[0]) begin
                            starve_cnt <= lo_req ? starve_cnt + SW'(1) : '0;
                        end else begin
                            starve_cnt <= '0;
                            rr_ptr     <= pick[1];
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ack_match) begin
                        sdram_wr_req <= 1'b0;
                        sdram_rd_req <= 1'b0;
                        ack_cnt      <= 9'd1;
                        state        <= XFER;
                    end
                end
                XFER: begin
                    if (ack_cnt == len_q) begin
                        state <= WAIT_IDLE;
                    end else begin
                        ack_cnt <= cnt_next;
                        if (cnt_next == len_q) state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (ctrl_idle) begin
                        done  <= grant;
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter: the bench plays the SDRAM controller and
// predicts each grant from a transaction-level priority/starvation model.
module tb_sdram_arbiter;

    localparam int ADDR_W     = 24;
    localparam int STARVE_MAX = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sdram_init_done;
    logic                ctrl_idle;
    logic [2:0]          req;
    logic [2:0]          req_wr;
    logic [3*ADDR_W-1:0] req_addr;
    logic [26:0]         req_len;
    logic [2:0]          grant;
    logic [2:0]          done;
    logic [2:0]          wr_ack_o;
    logic [2:0]          rd_ack_o;
    logic                sdram_wr_req;
    logic                sdram_rd_req;
    logic [8:0]          sdwr_byte;
    logic [8:0]          sdrd_byte;
    logic [ADDR_W-1:0]   sys_addr;
    logic                sdram_wr_ack;
    logic                sdram_rd_ack;

    int n_vec = 0;
    int n_err = 0;
    int starve_m;
    int rr_m;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done), .ctrl_idle(ctrl_idle),
        .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
        .grant(grant), .done(done), .wr_ack_o(wr_ack_o), .rd_ack_o(rd_ack_o),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdwr_byte(sdwr_byte), .sdrd_byte(sdrd_byte), .sys_addr(sys_addr),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > 256) return 256;
        return l;
    endfunction

    // Port 0 first unless it has won STARVE_MAX times in a row over waiting ports.
    function automatic int model_pick(input logic [2:0] r);
        bit lo = r[1] | r[2];
        if (r[0] && !(starve_m == STARVE_MAX && lo)) return 0;
        if (rr_m == 1) return r[1] ? 1 : 2;
        return r[2] ? 2 : 1;
    endfunction

    task automatic model_commit(input int w, input logic [2:0] r);
        if (w == 0) begin
            starve_m = (r[1] | r[2]) ? starve_m + 1 : 0;
        end else begin
            starve_m = 0;
            rr_m     = (w == 1) ? 2 : 1;
        end
    endtask

    task automatic reset_model();
        starve_m = 0;
        rr_m     = 1;
    endtask

    task automatic randomize_ports();
        req    = 3'($urandom_range(1, 7));
        req_wr = 3'($urandom);
        for (int p = 0; p < 3; p++) begin
            req_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            if ($urandom_range(0, 15) == 0) req_len[p*9 +: 9] = 9'($urandom_range(257, 511));
            else                            req_len[p*9 +: 9] = 9'($urandom_range(0, 12));
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_reqs"}, {sdram_wr_req, sdram_rd_req}, 0);
        check({tag, "_bytes"}, {sdwr_byte, sdrd_byte}, 0);
        check({tag, "_addr"}, sys_addr, 0);
        check({tag, "_acko"}, {wr_ack_o, rd_ack_o}, 0);
    endtask

    task automatic full_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sdram_init_done = 1'b1;
        ctrl_idle = 1'b1;
        reset_model();
    endtask

    task automatic check_route(input logic [2:0] mask);
        check("wr_ack_route", wr_ack_o, sdram_wr_ack ? mask : 3'b000);
        check("rd_ack_route", rd_ack_o, sdram_rd_ack ? mask : 3'b000);
    endtask

    // One full grant/transfer/done cycle; abort_after >= 0 resets mid-burst instead.
    task automatic run_txn(input int abort_after, input bit mid_rand, input bit release_req,
                           output int w_obs);
        logic [2:0]        r    = req;
        int                w    = model_pick(r);
        logic [2:0]        mask = 3'b001 << w;
        bit                wr   = req_wr[w];
        int                n    = clamp_len(int'(req_len[w*9 +: 9]));
        logic [ADDR_W-1:0] a    = req_addr[w*ADDR_W +: ADDR_W];
        bit                got  = 1'b0;
        w_obs = -1;
        for (int i = 0; i < 2 && !got; i++) begin
            @(negedge clk);
            if (grant != 3'b000) got = 1'b1;
        end
        check("grant", grant, mask);
        if (!got) return;
        w_obs = (grant == 3'b010) ? 1 : (grant == 3'b100) ? 2 : 0;
        check("sys_addr", sys_addr, a);
        check("sdwr_byte", sdwr_byte, n);
        check("sdrd_byte", sdrd_byte, n);
        check("issue_req", {sdram_wr_req, sdram_rd_req}, {wr, !wr});
        model_commit(w, r);
        ctrl_idle = 1'b0;
        if (mid_rand) randomize_ports();
        for (int k = 0; k < n; k++) begin
            if (k == abort_after) begin
                rst_n = 1'b0;
                #2;
                check_reset_outs("rst_mid");
                repeat (2) @(negedge clk);
                check_reset_outs("rst_hold");
                rst_n = 1'b1;
                ctrl_idle = 1'b1;
                reset_model();
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                if (wr) sdram_rd_ack = 1'($urandom_range(0, 1));
                else    sdram_wr_ack = 1'($urandom_range(0, 1));
                ctrl_idle = 1'($urandom_range(0, 1));
                #1;
                check_route(mask);
                if (k == 0) check("issue_hold", {sdram_wr_req, sdram_rd_req}, {wr, !wr});
                @(negedge clk);
                sdram_wr_ack = 1'b0;
                sdram_rd_ack = 1'b0;
                check("done_early", done, 0);
            end
            if (wr) sdram_wr_ack = 1'b1;
            else    sdram_rd_ack = 1'b1;
            ctrl_idle = 1'($urandom_range(0, 1));
            #1;
            check_route(mask);
            if (k == 0) check("issue_hold", {sdram_wr_req, sdram_rd_req}, {wr, !wr});
            @(negedge clk);
            sdram_wr_ack = 1'b0;
            sdram_rd_ack = 1'b0;
            check("done_early", done, 0);
            if (k == 0) check("req_drop", {sdram_wr_req, sdram_rd_req}, 0);
        end
        ctrl_idle = 1'b0;
        repeat (1 + $urandom_range(0, 2)) begin
            @(negedge clk);
            check("wait_idle_done", done, 0);
            check("wait_idle_grant", grant, mask);
        end
        ctrl_idle = 1'b1;
        if (release_req) req = 3'b000;
        @(negedge clk);
        check("done_pulse", done, mask);
        check("grant_clear", grant, 0);
        @(negedge clk);
        check("done_single", done, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        ctrl_idle = 1'b0;
        req = '0;
        req_wr = '0;
        req_addr = '0;
        req_len = '0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        reset_model();
        #2;
        check_reset_outs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Controller not ready: requests stay pending
        req = 3'b111;
        req_wr = 3'b010;
        req_len = {9'd2, 9'd2, 9'd2};
        repeat (5) @(negedge clk);
        check("no_grant_uninit", grant, 0);
        ctrl_idle = 1'b1;
        repeat (3) @(negedge clk);
        check("no_grant_init_low", grant, 0);
        sdram_init_done = 1'b1;
        run_txn(-1, 1'b0, 1'b1, w);

        // Port 2 read, len 4 at 0x000100
        req = 3'b100; req_wr = 3'b000;
        req_addr[2*ADDR_W +: ADDR_W] = 24'h000100;
        req_len[18 +: 9] = 9'd4;
        run_txn(-1, 1'b0, 1'b1, w);

        // Port 1 write, len 0 clamps to 1
        req = 3'b010; req_wr = 3'b010;
        req_len[9 +: 9] = 9'd0;
        run_txn(-1, 1'b0, 1'b1, w);

        // Port 0 read, len 300 clamps to 256
        req = 3'b001; req_wr = 3'b000;
        req_addr[0 +: ADDR_W] = 24'hABCDEF;
        req_len[0 +: 9] = 9'd300;
        run_txn(-1, 1'b0, 1'b1, w);

        // Reset after 3 of 8 acks, then a fresh grant
        req = 3'b010; req_wr = 3'b000;
        req_len[9 +: 9] = 9'd8;
        run_txn(3, 1'b0, 1'b0, w);
        req = 3'b100; req_wr = 3'b100;
        req_len[18 +: 9] = 9'd5;
        run_txn(-1, 1'b0, 1'b1, w);

        // All ports requesting: 8x port 0, port 1, 8x port 0, port 2
        full_reset();
        req = 3'b111; req_wr = 3'($urandom);
        req_len = {9'd1, 9'd2, 9'd1};
        for (int i = 0; i < 18; i++) begin
            run_txn(-1, 1'b0, (i == 17), w);
            check("starve_seq", w, (i % 9 < 8) ? 0 : (((i / 9) % 2 == 0) ? 1 : 2));
        end

        randomize_ports();
        for (int i = 0; i < 40; i++) run_txn(-1, 1'b1, 1'b0, w);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24: SDRAM word address width per port.
REQ-002 Parameter STARVE_MAX, default 8: consecutive port-0 grants allowed before a low-priority port is forced.
REQ-003 clk  in  1  system clock, 100MHz; the block SHALL use this single clock only.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 sdram_init_done  in  1  high once the SDRAM controller has completed initialization.
REQ-006 ctrl_idle  in  1  high when the controller work state is idle.
REQ-007 req  in  3  per-port level request, one bit per port; port 0 is the video fetch port.
REQ-008 req_wr  in  3  per-port direction: 1 = write, 0 = read.
REQ-009 req_addr  in  3*ADDR_W  packed start addresses; port n occupies bits [n*ADDR_W +: ADDR_W].
REQ-010 req_len  in  27  packed 9-bit burst lengths; port n occupies bits [n*9 +: 9].
REQ-011 grant  out  3  one-hot current owner; all zero when no port owns the controller.
REQ-012 done  out  3  one-cycle pulse to the owner when its transaction ends.
REQ-013 wr_ack_o / rd_ack_o  out  3 each  controller acks routed to the owner only.
REQ-014 sdram_wr_req / sdram_rd_req  out  1 each  requests to the controller.
REQ-015 sdwr_byte / sdrd_byte  out  9 each  latched burst length.
REQ-016 sys_addr  out  ADDR_W  latched start address.
REQ-017 sdram_wr_ack / sdram_rd_ack  in  1 each  per-word acks from the controller.

Function
REQ-018 FSM states: IDLE, ISSUE, XFER, WAIT_IDLE.
REQ-019 IDLE: when sdram_init_done && ctrl_idle && |req, the FSM SHALL select a winner, latch its address, length and direction, set grant, and move to ISSUE on the next edge.
REQ-020 Priority: port 0 wins over ports 1 and 2, except per REQ-021; ports 1 and 2 alternate round-robin, with pointer initial value port 1 and the pointer advancing past the port just served.
REQ-021 A starve counter SHALL count consecutive port-0 grants while port 1 or port 2 is requesting; when the counter equals STARVE_MAX, the next arbitration SHALL exclude port 0. The counter SHALL clear on any port-1 or port-2 grant.
REQ-022 Length clamp: latched len 0 SHALL become 1; len > 256 SHALL become 256.
REQ-023 ISSUE: assert sdram_wr_req or sdram_rd_req according to the latched direction, and hold it until the first matching ack; deassert it in the ack cycle; move to XFER.
REQ-024 XFER: a 9-bit counter SHALL count matching acks, including the first. When the count equals the latched len, the FSM SHALL move to WAIT_IDLE.
REQ-025 WAIT_IDLE: when ctrl_idle is high, pulse done for the owner, clear grant, and return to IDLE. Back-to-back grants therefore have a minimum gap of 1 cycle in IDLE.
REQ-026 Ack routing: wr_ack_o[n] = sdram_wr_ack && grant[n]; rd_ack_o[n] = sdram_rd_ack && grant[n]. Both are combinational and zero-latency.
REQ-027 Acks of the non-matching direction, and acks arriving in IDLE, SHALL be ignored and not counted.
REQ-028 A requester dropping req mid-transaction SHALL NOT abort it; the transaction completes normally.
REQ-029 Refresh by the controller while a request is held SHALL only delay the first ack; no special handling is required.
REQ-030 Simultaneous done and a new request from the same port: that port is re-eligible only from the next IDLE cycle.
REQ-031 sdram_init_done low: no grant is issued; requests remain pending.

Reset
REQ-032 While rst_n is low, at any point including mid-burst: FSM = IDLE; grant, done, sdram_wr_req, sdram_rd_req, sdwr_byte, sdrd_byte, sys_addr, ack counter and starve counter = 0; round-robin pointer = port 1.

Verification
REQ-033 Port 2 read request with len 4, addr 0x000100 -> grant = 3'b100, sdram_rd_req high until the first rd_ack, rd_ack_o[2] pulses 4 times, done[2] pulses once after ctrl_idle.
REQ-034 All three ports request continuously, STARVE_MAX = 8 -> grant sequence is 8x port 0, port 1, 8x port 0, port 2, repeating.
REQ-035 Port 1 write with len 0 -> sdwr_byte = 1; done after 1 wr_ack.
REQ-036 Port 0 read with len 300 -> sdrd_byte = 256; done after 256 acks.
REQ-037 Assert rst_n low after 3 of 8 acks -> all outputs 0 within the reset window; after release, a new request is granted normally.
REQ-038 sdram_init_done low with all requests high -> grant remains 0; grant asserts within 2 cycles after sdram_init_done and ctrl_idle both rise.
